// File: rtl/essr_bank.sv
// Bank of N redundant-pair mismatch monitors. Each channel has a persistence filter,
// a set/reset/conflict status element, a live count of set channels and a sticky irq.
module essr_bank #(
    parameter int N       = 8,
    parameter int PERSIST = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N-1:0]                      x,
    input  logic [N-1:0]                      z,
    input  logic [N-1:0]                      r,
    input  logic                              ack,
    output logic [N-1:0]                      g,
    output logic [N-1:0]                      gn,
    output logic                              conflict,
    output logic [$clog2(N+1)-1:0]            active_cnt,
    output logic                              irq,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] irq_ch
);

    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(N + 1);

    logic [3:0]   pc [N];
    logic [N-1:0] m;
    logic [N-1:0] s;
    logic [N-1:0] next_g;
    logic [N-1:0] next_gn;
    logic [N-1:0] ev;
    logic [CW-1:0] first_ev;

    // s fires on the PERSIST-th consecutive mismatch sample, judged on the pre-edge count.
    always_comb begin
        m       = x ^ z;
        s       = '0;
        next_g  = g;
        next_gn = gn;
        ev      = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = m[i] && (pc[i] >= 4'(PERSIST - 1));
            case ({s[i], r[i]})
                2'b01:   begin next_g[i] = 1'b0; next_gn[i] = 1'b1; end
                2'b10:   begin next_g[i] = 1'b1; next_gn[i] = 1'b0; end
                2'b11:   begin next_g[i] = 1'b1; next_gn[i] = 1'b1; end
                default: begin next_g[i] = g[i]; next_gn[i] = gn[i]; end
            endcase
            ev[i] = (({g[i], gn[i]} == 2'b01) && next_g[i])
                 || (({g[i], gn[i]} == 2'b10) && ({next_g[i], next_gn[i]} == 2'b11));
        end
    end

    always_comb begin
        first_ev = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ev[i]) first_ev = CW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) pc[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!m[i])
                    pc[i] <= '0;
                else if (pc[i] < 4'(PERSIST))
                    pc[i] <= pc[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g  <= '0;
            gn <= '1;
        end else begin
            g  <= next_g;
            gn <= next_gn;
        end
    end

    // irq_ch keeps the first pending source unless an ack hands over to a coincident event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq    <= 1'b0;
            irq_ch <= '0;
        end else if (|ev) begin
            irq <= 1'b1;
            if (!irq || ack) irq_ch <= first_ev;
        end else if (ack) begin
            irq <= 1'b0;
        end
    end

    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < N; i++) begin
            active_cnt = active_cnt + CNTW'(g[i] & ~gn[i]);
        end
    end

    assign conflict = |(g & gn);

endmodule

// File: doc/essr_bank.md
# essr_bank

Parametrised multi-channel successor to the single-channel set/reset status element used for fault/mismatch flagging. Each channel compares a pair of redundant inputs; a disagreement that persists for a programmable number of cycles sets the channel, and a per-channel reset clears it. The bank adds an asynchronous active-low reset, a mismatch persistence filter, a live count of set channels, and a sticky interrupt with acknowledge. It sits between the redundant datapaths and the fault-management controller.

## Interface

Parameters:
- `N`, default 8, is the number of channels, with a range of 1..32.
- `PERSIST`, default 1, is the number of consecutive mismatch samples required to assert set, with a range of 1..15. A value of 1 gives the legacy behaviour.

Ports:
- `clk`, input, 1 bit. The single clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit. Reset, asynchronous and active-low.
- `x`, input, N bits. Channel A inputs.
- `z`, input, N bits. Channel B inputs.
- `r`, input, N bits. Per-channel reset request (synchronous, active-high).
- `g`, output, N bits. Per-channel status, registered.
- `gn`, output, N bits. Per-channel complementary status, registered.
- `conflict`, output, 1 bit. OR over channels of (g & gn).
- `active_cnt`, output, $clog2(N+1) bits. Number of channels in SET state.
- `irq`, output, 1 bit. Sticky event interrupt, registered.
- `irq_ch`, output, max(1,$clog2(N)) bits. Channel that raised the pending irq, registered.
- `ack`, input, 1 bit. Interrupt acknowledge, single-cycle pulse.

## Operation

- Per-channel raw mismatch: m[i] = x[i] ^ z[i], sampled on each rising edge.
- Persistence counter pc[i], 4 bits:
  - clears to 0 when m[i]=0;
  - otherwise increments, saturating at PERSIST.
- Filtered set: s[i] = m[i] & (pc[i] >= PERSIST-1), where pc[i] is the value before the edge. It is asserted on the PERSIST-th consecutive mismatch sample and every sample after that while the mismatch holds.
- Channel state is encoded as {g,gn}:
  - IDLE = 01
  - SET = 10
  - CONFLICT = 11
  - The encoding 00 is unreachable.
- Transitions on each edge, by {s[i], r[i]}:
  - 00: hold.
  - 01: go to IDLE.
  - 10: go to SET.
  - 11: go to CONFLICT.
  - CONFLICT is held until the next non-00 combination.
- r[i] does not clear pc[i]. The persistence filter runs independently of channel state.
- Events:
  - A channel raises an event on an edge where its state moves from IDLE to SET or CONFLICT.
  - A SET→CONFLICT transition also raises an event.
  - Staying in the same state raises no event.
- irq behaviour:
  - irq sets on any event.
  - irq clears on an edge with ack=1 and no event in that same edge.
  - If ack and an event coincide, irq stays 1 and irq_ch takes the new event's channel.
- irq_ch:
  - Loads the lowest-index channel with an event, only when irq is 0 before the edge, or on the ack+event coincidence.
  - Otherwise it holds, so the first pending source is preserved.
- active_cnt is a combinational popcount of (g & ~gn) over the registered state. It adds no latency relative to g/gn.
- conflict is combinational from the registered g/gn.

## Timing

- Reset (rst_n=0, asynchronous, takes effect immediately):
  - g=0, gn=all 1s, every pc=0;
  - irq=0, irq_ch=0;
  - active_cnt=0, conflict=0.
- Release of rst_n is synchronous in effect: the first state update is at the first rising edge with rst_n=1.
- Latency with PERSIST=P: a mismatch applied before edge k, and held, gives g=1 after edge k+P-1.
  - With P=1, g rises after edge k, i.e. one cycle.
- Reset request: r[i]=1 before edge k (with s[i]=0) gives {g,gn}=01 after edge k.
- irq asserts after the same edge that changes g/gn.
- ack sampled at edge k gives irq=0 after edge k, unless an event occurs at edge k.
- A mismatch glitch shorter than P samples leaves the channel state untouched.
  - Any single m=0 sample restarts the count.
- Asserting rst_n mid-filter discards partial counts. Asserting it with irq pending drops the irq without an ack.

## Test plan

- **Reset values.** N=8, P=1: assert rst_n=0 mid-cycle. Required: g=0x00, gn=0xFF, irq=0, active_cnt=0 immediately, with no clock edge needed.
- **Legacy truth table.** N=8, P=1, channel 2: drive {s,r} = 10, 00, 11, 00, 01. Required {g[2],gn[2]} after each edge: 10, 10, 11, 11, 01. Required conflict: 1 only while the state is 11.
- **Persistence filter.** P=3, channel 0: drive mismatch for 2 cycles, 1 match cycle, then 3 mismatch cycles. Required: g[0] stays 0 until the edge of the third consecutive mismatch, then becomes 1. active_cnt goes 0→1 on that same edge.
- **Interrupt stickiness and source.** P=1: channels 5 and 3 mismatch on the same edge, then channel 6 mismatches 2 cycles later. Required: irq=1, irq_ch=3, and irq_ch still 3 after the channel 6 event.
- **ack/event collision.** With irq pending, pulse ack on the same edge channel 7 goes IDLE→SET. Required: irq remains 1 and irq_ch=7. A later ack alone gives irq=0.
- **Count and full load.** N=8, P=1: all channels mismatch. Required: active_cnt=8. Then set r=0x0F with mismatch held: channels 0–3 go to CONFLICT (11) and active_cnt=4. Then release the mismatch with r=0xFF: all channels go to IDLE and active_cnt=0.
